// File: rtl/pwm_duty_decoder.sv
// pwm_duty_decoder: recovers width and period of a PWM line measured between rising edges
// Ports:
//   i_clk        system clock, all logic on the rising edge
//   i_rst        synchronous active-high reset
//   i_pwm_in     PWM line, asynchronous to i_clk
//   o_width_out  high cycles of the last complete period (or 0/TIMEOUT on a stuck report)
//   o_period_out cycles between the last two rising edges (or TIMEOUT on a stuck report)
//   o_valid      one-cycle strobe: o_width_out/o_period_out just updated
//   o_stuck      high while no rising edge has been seen for TIMEOUT cycles
module pwm_duty_decoder #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 2000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_pwm_in,
    output logic [CNT_W-1:0] o_width_out,
    output logic [CNT_W-1:0] o_period_out,
    output logic             o_valid,
    output logic             o_stuck
);
    typedef enum logic {IDLE, MEASURE} state_t;
    state_t           r_state;
    logic             r_s1, r_s2, r_s3;
    logic [CNT_W-1:0] r_per_cnt, r_hi_cnt;
    logic             w_rise, w_timeout;
    assign w_rise = r_s2 & ~r_s3;
    // a rise landing on the timeout cycle is a genuine period of exactly TIMEOUT
    assign w_timeout = ~w_rise && (r_per_cnt == CNT_W'(TIMEOUT));
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1         <= 1'b0;
            r_s2         <= 1'b0;
            r_s3         <= 1'b0;
            r_per_cnt    <= '0;
            r_hi_cnt     <= '0;
            o_width_out  <= '0;
            o_period_out <= '0;
            o_valid      <= 1'b0;
            o_stuck      <= 1'b0;
            r_state      <= IDLE;
        end else begin
            r_s1      <= i_pwm_in;
            r_s2      <= r_s1;
            r_s3      <= r_s2;
            r_per_cnt <= (w_rise || w_timeout) ? CNT_W'(1) : r_per_cnt + CNT_W'(1);
            r_hi_cnt  <= w_rise ? CNT_W'(1) : r_hi_cnt + CNT_W'(r_s2);
            o_valid   <= 1'b0;
            if (w_rise) begin
                // the period closing at the first rise after IDLE is partial, so it is dropped
                if (r_state == MEASURE) begin
                    o_width_out  <= r_hi_cnt;
                    o_period_out <= r_per_cnt;
                    o_valid      <= 1'b1;
                end else begin
                    o_stuck <= 1'b0;
                end
                r_state <= MEASURE;
            end else if (w_timeout) begin
                o_width_out  <= r_s2 ? CNT_W'(TIMEOUT) : '0;
                o_period_out <= CNT_W'(TIMEOUT);
                o_valid      <= 1'b1;
                o_stuck      <= 1'b1;
                r_state      <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_pwm_duty_decoder.sv
// tb_pwm_duty_decoder: event-timestamp model plus directed PWM scenarios for pwm_duty_decoder
module tb_pwm_duty_decoder;
    localparam int TO = 2000;
    localparam int N  = 65536;
    logic        clk = 1'b0, rst = 1'b1, pwm = 1'b0;
    logic [31:0] o_w, o_p;
    logic        o_v, o_s;
    int          checks = 0, errors = 0;
    pwm_duty_decoder #(.CNT_W(32), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst(rst), .i_pwm_in(pwm),
        .o_width_out(o_w), .o_period_out(o_p), .o_valid(o_v), .o_stuck(o_s)
    );
    always #5 clk = ~clk;
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30) $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask
    // model: line value seen by the decoder at edge n is the input two edges earlier,
    // forced low when either of the two edges in between was a reset edge
    bit          pw [N], rs [N], ln [N];
    int          cyc = 0, last = 0;
    bit          kind = 0, armed = 0;
    logic [31:0] e_w = 0, e_p = 0;
    logic        e_v = 0, e_s = 0;
    always @(posedge clk) begin
        automatic int n;
        automatic bit l;
        automatic int s;
        n = cyc;
        cyc <= cyc + 1;
        pw[n] <= pwm;
        rs[n] <= rst;
        if (rst) begin
            ln[n] <= 1'b0;
            e_w <= 0; e_p <= 0; e_v <= 0; e_s <= 0;
            last <= n + 1; kind <= 1'b0; armed <= 1'b1;
        end else begin
            l = (n >= 2 && !rs[n-1] && !rs[n-2]) ? pw[n-2] : 1'b0;
            ln[n] <= l;
            e_v <= 1'b0;
            if (l && !ln[n-1]) begin
                if (kind) begin
                    s = 0;
                    for (int k = last; k < n; k++) s += int'(ln[k]);
                    e_w <= s; e_p <= n - last; e_v <= 1'b1;
                end else e_s <= 1'b0;
                last <= n; kind <= 1'b1;
            end else if (n - last == TO) begin
                e_w <= l ? TO : 0; e_p <= TO; e_v <= 1'b1; e_s <= 1'b1;
                last <= n; kind <= 1'b0;
            end
        end
    end
    always @(negedge clk) if (armed) begin
        check("valid", o_v, e_v);
        check("stuck", o_s, e_s);
        check("width", o_w, e_w);
        check("period", o_p, e_p);
    end
    int          nv, fj, lat;
    logic [31:0] lw, lp;
    // drives n periods of h high / p total cycles and records the strobes seen meanwhile
    task automatic gen(input int h, input int p, input int n);
        nv = 0; fj = -1; lat = -1; lw = 0; lp = 0;
        for (int k = 0; k < n; k++)
            for (int i = 0; i < p; i++) begin
                @(negedge clk);
                if (o_v) begin
                    nv++;
                    if (fj < 0) fj = k * p + i;
                    lw = o_w; lp = o_p; lat = i;
                end
                pwm = (i < h);
            end
    endtask
    task automatic zeros(input string nm);
        check({nm, "_w"}, o_w, 0);
        check({nm, "_p"}, o_p, 0);
        check({nm, "_v"}, o_v, 0);
        check({nm, "_s"}, o_s, 0);
    endtask
    initial begin
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            zeros("rst");
            pwm = ~pwm;
        end
        @(negedge clk);
        rst = 1'b0; pwm = 1'b0;
        gen(250, 1000, 4);
        check("steady_n", nv, 3); check("steady_first", fj, 1003); check("latency", lat, 3);
        check("steady_w", lw, 250); check("steady_p", lp, 1000);
        gen(1, 1000, 3);
        check("h1_n", nv, 3); check("h1_w", lw, 1); check("h1_p", lp, 1000);
        gen(999, 1000, 3);
        check("h999_n", nv, 3); check("h999_w", lw, 999); check("h999_p", lp, 1000);
        gen(300, 500, 3);
        check("p500_n", nv, 3); check("p500_w", lw, 300); check("p500_p", lp, 500);
        gen(0, 6000, 1);
        check("lo_n", nv, 3); check("lo_first", fj, 1503); check("lo_last", lat, 5503);
        check("lo_w", lw, 0); check("lo_p", lp, TO); check("lo_s", o_s, 1);
        gen(400, 1000, 2);
        check("resume_n", nv, 1); check("resume_w", lw, 400); check("resume_p", lp, 1000);
        check("resume_s", o_s, 0);
        gen(5000, 5000, 1);
        check("hi_n", nv, 3); check("hi_first", fj, 3);
        check("hi_w", lw, TO); check("hi_p", lp, TO); check("hi_s", o_s, 1);
        gen(250, 1000, 3);
        check("rec_n", nv, 1); check("rec_w", lw, 250); check("rec_s", o_s, 0);
        gen(0, 300, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        zeros("midrst");
        rst = 1'b0;
        gen(250, 1000, 3);
        check("post_n", nv, 2); check("post_first", fj, 1003);
        check("post_w", lw, 250); check("post_p", lp, 1000);
        gen(700, TO, 3);
        check("tie_n", nv, 3); check("tie_w", lw, 700); check("tie_p", lp, TO);
        check("tie_s", o_s, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
